// File: rtl/mac_learn_lookup.sv
// Source-learning / destination-lookup sequencer that drives an external registered CAM.
// Optional build macro MAC_MOVE_EN: a known source seen on a new port is deleted and relearned.
module mac_learn_lookup #(
    parameter int KEY_WIDTH  = 48,
    parameter int PORT_COUNT = 8
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          header_valid,
    output logic                          header_ready,
    input  logic [KEY_WIDTH-1:0]          src_mac,
    input  logic [KEY_WIDTH-1:0]          dst_mac,
    input  logic [$clog2(PORT_COUNT)-1:0] ingress_port,
    output logic                          cam_write_enable,
    output logic                          cam_match_enable,
    output logic                          cam_delete_enable,
    output logic [KEY_WIDTH-1:0]          cam_key,
    output logic [$clog2(PORT_COUNT)-1:0] cam_index,
    input  logic [$clog2(PORT_COUNT)-1:0] cam_match_index,
    input  logic                          cam_match_valid,
    input  logic                          cam_no_match,
    output logic                          result_valid,
    input  logic                          result_ready,
    output logic [PORT_COUNT-1:0]         dest_port_mask,
    output logic [15:0]                   learn_count
);
    localparam int PW = $clog2(PORT_COUNT);
    // Group (multicast/broadcast) bit: LSB of the first octet, bit 40 of a 48-bit MAC.
    localparam int GROUP_BIT = KEY_WIDTH - 8;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] SRC_REQ  = 3'd1;
    localparam logic [2:0] SRC_WAIT = 3'd2;
    localparam logic [2:0] DELETE   = 3'd3;
    localparam logic [2:0] LEARN    = 3'd4;
    localparam logic [2:0] DST_REQ  = 3'd5;
    localparam logic [2:0] DST_WAIT = 3'd6;
    localparam logic [2:0] RESULT   = 3'd7;

    localparam logic [PORT_COUNT-1:0] ONE = {{(PORT_COUNT-1){1'b0}}, 1'b1};

    logic [2:0]            state_reg, state_next;
    logic [KEY_WIDTH-1:0]  src_mac_reg, dst_mac_reg;
    logic [PW-1:0]         port_reg;
    logic [PORT_COUNT-1:0] mask_reg, mask_next;
    logic [15:0]           count_reg;
    logic                  alive_reg;

    logic                  cam_hit;
    logic [PORT_COUNT-1:0] flood_mask;
    logic [2:0]            after_src;

    assign cam_hit    = cam_match_valid & ~cam_no_match;
    assign flood_mask = ~(ONE << port_reg);
    // Group destinations never need a lookup: they flood straight away.
    assign after_src  = dst_mac_reg[GROUP_BIT] ? RESULT : DST_REQ;

    always_comb begin
        state_next = state_reg;
        mask_next  = mask_reg;
        case (state_reg)
            IDLE: begin
                if (header_valid && header_ready)
                    state_next = SRC_REQ;
            end
            SRC_REQ: state_next = SRC_WAIT;
            SRC_WAIT: begin
                state_next = after_src;
                mask_next  = flood_mask;
                if (!cam_hit && !src_mac_reg[GROUP_BIT])
                    state_next = LEARN;
`ifdef MAC_MOVE_EN
                if (cam_hit && (cam_match_index != port_reg))
                    state_next = DELETE;
`endif
            end
            DELETE: state_next = LEARN;
            LEARN: begin
                state_next = after_src;
                mask_next  = flood_mask;
            end
            DST_REQ: state_next = DST_WAIT;
            DST_WAIT: begin
                state_next = RESULT;
                if (!cam_hit)
                    mask_next = flood_mask;
                else if (cam_match_index == port_reg)
                    mask_next = '0;
                else
                    mask_next = ONE << cam_match_index;
            end
            RESULT: begin
                if (result_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            src_mac_reg <= '0;
            dst_mac_reg <= '0;
            port_reg    <= '0;
            mask_reg    <= '0;
            count_reg   <= '0;
            alive_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            mask_reg  <= mask_next;
            alive_reg <= 1'b1;
            if (state_reg == IDLE && header_valid && header_ready) begin
                src_mac_reg <= src_mac;
                dst_mac_reg <= dst_mac;
                port_reg    <= ingress_port;
            end
            // Counts issued writes, including ones a full CAM drops.
            if (state_reg == LEARN && count_reg != 16'hFFFF)
                count_reg <= count_reg + 16'd1;
        end
    end

    // alive_reg keeps header_ready low until the first clock after reset release.
    assign header_ready      = alive_reg && (state_reg == IDLE);
    assign result_valid      = (state_reg == RESULT);
    assign dest_port_mask    = mask_reg;
    assign learn_count       = count_reg;
    assign cam_match_enable  = (state_reg == SRC_REQ) || (state_reg == DST_REQ);
    assign cam_write_enable  = (state_reg == LEARN);
    assign cam_delete_enable = (state_reg == DELETE);
    assign cam_index         = (state_reg == LEARN) ? port_reg : '0;

    always_comb begin
        cam_key = '0;
        case (state_reg)
            SRC_REQ, DELETE, LEARN: cam_key = src_mac_reg;
            DST_REQ:                cam_key = dst_mac_reg;
            default:                cam_key = '0;
        endcase
    end
endmodule

// File: tb/tb_mac_learn_lookup.sv
// Randomized bench for mac_learn_lookup: behavioural CAM, forwarding-table reference model.
// Honours MAC_MOVE_EN the same way as the design.
module tb_mac_learn_lookup;
    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        header_valid;
    logic        header_ready;
    logic [47:0] src_mac, dst_mac;
    logic [2:0]  ingress_port;
    logic        cam_write_enable, cam_match_enable, cam_delete_enable;
    logic [47:0] cam_key;
    logic [2:0]  cam_index;
    logic [2:0]  cam_match_index = '0;
    logic        cam_match_valid = 1'b0;
    logic        cam_no_match = 1'b0;
    logic        result_valid;
    logic        result_ready;
    logic [7:0]  dest_port_mask;
    logic [15:0] learn_count;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    mac_learn_lookup #(.KEY_WIDTH(48), .PORT_COUNT(8)) dut (
        .clock(clock), .reset_n(reset_n),
        .header_valid(header_valid), .header_ready(header_ready),
        .src_mac(src_mac), .dst_mac(dst_mac), .ingress_port(ingress_port),
        .cam_write_enable(cam_write_enable), .cam_match_enable(cam_match_enable),
        .cam_delete_enable(cam_delete_enable), .cam_key(cam_key), .cam_index(cam_index),
        .cam_match_index(cam_match_index), .cam_match_valid(cam_match_valid),
        .cam_no_match(cam_no_match),
        .result_valid(result_valid), .result_ready(result_ready),
        .dest_port_mask(dest_port_mask), .learn_count(learn_count)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural external CAM (registered lookup) ----------------
    int          n_write = 0, n_del = 0, n_match = 0, multi_en_errs = 0;
    logic [47:0] last_wkey = '0;
    logic [2:0]  last_widx = '0;
    bit          cam_used [DEPTH];
    logic [47:0] cam_keys [DEPTH];
    logic [2:0]  cam_ports [DEPTH];

    function automatic int cam_find(input logic [47:0] k);
        for (int i = 0; i < DEPTH; i++)
            if (cam_used[i] && cam_keys[i] == k) return i;
        return -1;
    endfunction

    function automatic int cam_slot(input logic [47:0] k);
        if (cam_find(k) >= 0) return cam_find(k);
        for (int i = 0; i < DEPTH; i++)
            if (!cam_used[i]) return i;
        return -1;
    endfunction

    always @(posedge clock) begin
        cam_match_valid <= 1'b0;
        cam_no_match    <= 1'b0;
        if (int'(cam_write_enable) + int'(cam_match_enable) + int'(cam_delete_enable) > 1)
            multi_en_errs <= multi_en_errs + 1;
        if (cam_match_enable) begin
            n_match <= n_match + 1;
            if (cam_find(cam_key) >= 0) begin
                cam_match_valid <= 1'b1;
                cam_match_index <= cam_ports[3'(cam_find(cam_key))];
            end else begin
                cam_no_match <= 1'b1;
            end
        end
        if (cam_write_enable) begin
            n_write   <= n_write + 1;
            last_wkey <= cam_key;
            last_widx <= cam_index;
            if (cam_slot(cam_key) >= 0) begin
                cam_used[3'(cam_slot(cam_key))]  <= 1'b1;
                cam_keys[3'(cam_slot(cam_key))]  <= cam_key;
                cam_ports[3'(cam_slot(cam_key))] <= cam_index;
            end
        end
        if (cam_delete_enable) begin
            n_del <= n_del + 1;
            if (cam_find(cam_key) >= 0)
                cam_used[3'(cam_find(cam_key))] <= 1'b0;
        end
    end

    // ---------------- reference model: MAC -> port table ----------------
    int model_tab [logic [47:0]];
    int exp_lc = 0;
    int frame_no = 0;

    task automatic model_learn(input logic [47:0] k, input int p);
        if (model_tab.exists(k) || model_tab.num() < DEPTH) model_tab[k] = p;
        if (exp_lc < 65535) exp_lc++;
    endtask

    task automatic run_frame(input logic [47:0] s, input logic [47:0] d, input int p, input int hold);
        int lat, w0, d0, m0, el, ew, ed, emc;
        logic [7:0] em, flood;
        flood = 8'hFF;
        flood[p] = 1'b0;
        el = 5; ew = 0; ed = 0; emc = 1;
        if (!model_tab.exists(s)) begin
            if (!s[40]) begin
                el++; ew = 1;
                model_learn(s, p);
            end
        end
`ifdef MAC_MOVE_EN
        else if (model_tab[s] != p) begin
            el += 2; ew = 1; ed = 1;
            model_tab.delete(s);
            model_learn(s, p);
        end
`endif
        if (d[40]) begin
            el -= 2;
            em = flood;
        end else begin
            emc = 2;
            if (model_tab.exists(d))
                em = (model_tab[d] == p) ? 8'h00 : (8'h01 << model_tab[d]);
            else
                em = flood;
        end

        w0 = n_write; d0 = n_del; m0 = n_match;
        @(negedge clock);
        src_mac = s; dst_mac = d; ingress_port = p[2:0]; header_valid = 1'b1;
        lat = 0;
        while (!header_ready && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        if (!header_ready) begin
            check_eq("handshake_timeout", 64'(header_ready), 64'd1);
            header_valid = 1'b0;
            return;
        end
        @(posedge clock);
        #1 header_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!result_valid && lat < 20);
        check_eq("latency", 64'(lat), 64'(el));
        check_eq("mask", 64'(dest_port_mask), 64'(em));
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            check_eq("hold_valid", 64'(result_valid), 64'd1);
            check_eq("hold_mask", 64'(dest_port_mask), 64'(em));
            check_eq("hold_header_ready", 64'(header_ready), 64'd0);
        end
        result_ready = 1'b1;
        @(negedge clock);
        result_ready = 1'b0;
        check_eq("valid_drop", 64'(result_valid), 64'd0);
        check_eq("header_ready_back", 64'(header_ready), 64'd1);
        check_eq("learn_count", 64'(learn_count), 64'(exp_lc));
        check_eq("writes", 64'(n_write - w0), 64'(ew));
        check_eq("deletes", 64'(n_del - d0), 64'(ed));
        check_eq("matches", 64'(n_match - m0), 64'(emc));
        if (ew != 0) begin
            check_eq("write_key", 64'(last_wkey), 64'(s));
            check_eq("write_index", 64'(last_widx), 64'(p));
        end
        $display("frame %0d src=%012h dst=%012h port=%0d mask=%02h exp=%02h lat=%0d exp_lat=%0d lc=%0d",
                 frame_no, s, d, p, dest_port_mask, em, lat, el, learn_count);
        frame_no++;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_hdr_ready"}, 64'(header_ready), 64'd0);
        check_eq({tag, "_result_valid"}, 64'(result_valid), 64'd0);
        check_eq({tag, "_mask"}, 64'(dest_port_mask), 64'd0);
        check_eq({tag, "_learn_count"}, 64'(learn_count), 64'd0);
        check_eq({tag, "_cam_cmds"}, 64'({cam_write_enable, cam_match_enable, cam_delete_enable}), 64'd0);
        check_eq({tag, "_cam_key"}, 64'(cam_key), 64'd0);
        check_eq({tag, "_cam_index"}, 64'(cam_index), 64'd0);
    endtask

    logic [47:0] pool [12];

    initial begin
        int w0, lat;
        logic [47:0] s, d;
        reset_n = 1'b0; header_valid = 1'b0; result_ready = 1'b0;
        src_mac = '0; dst_mac = '0; ingress_port = '0;
        #1 check_all_zero("reset");
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        #1 check_eq("ready_before_clock", 64'(header_ready), 64'd0);
        @(negedge clock);
        check_eq("ready_after_release", 64'(header_ready), 64'd1);

        // result_ready while idle must be ignored
        result_ready = 1'b1;
        repeat (3) @(negedge clock);
        check_eq("idle_ready_ignored", 64'(result_valid), 64'd0);
        check_eq("idle_header_ready", 64'(header_ready), 64'd1);
        result_ready = 1'b0;

        // directed cases
        run_frame(48'h020000000001, 48'h02AABBCCDDEE, 3, 0);  // learn, flood F7 at T+6
        run_frame(48'h020000000005, 48'h020000000001, 5, 1);  // mask 08
        run_frame(48'h020000000010, 48'hFFFFFFFFFFFF, 0, 0);  // learn + broadcast
        run_frame(48'h020000000010, 48'hFFFFFFFFFFFF, 0, 0);  // known + broadcast: FE at T+3
        run_frame(48'h020000000001, 48'h02AABBCCDDEE, 6, 0);  // station move (or stale keep)
        run_frame(48'h020000000020, 48'h020000000020, 2, 0);  // src==dst: learn then drop
        run_frame(48'h020000000005, 48'h020000000010, 5, 10); // long backpressure

        // randomized traffic over a pool larger than the CAM so full-CAM drops occur
        for (int i = 0; i < 10; i++) pool[i] = 48'h020000000100 + 48'(i);
        pool[10] = 48'hFFFFFFFFFFFF;
        pool[11] = 48'h01005E000001;
        for (int i = 0; i < 40; i++) begin
            s = pool[$urandom_range(11)];
            d = ($urandom_range(3) == 0) ? s : pool[$urandom_range(11)];
            run_frame(s, d, int'($urandom_range(7)), int'($urandom_range(3)));
        end

        // reset during LEARN discards the pending write
        w0 = n_write;
        @(negedge clock);
        src_mac = 48'h0A0000000099; dst_mac = 48'h02AABBCCDDEE; ingress_port = 3'd4;
        header_valid = 1'b1;
        @(posedge clock);
        #1 header_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!cam_write_enable && lat < 10);
        check_eq("reached_learn", 64'(cam_write_enable), 64'd1);
        reset_n = 1'b0;
        #1 check_all_zero("reset_in_learn");
        repeat (2) @(posedge clock);
        #1 check_eq("no_write_after_reset", 64'(n_write - w0), 64'd0);
        exp_lc = 0;
        @(negedge clock);
        reset_n = 1'b1;
        #1 check_eq("ready_before_clock2", 64'(header_ready), 64'd0);
        @(negedge clock);
        check_eq("ready_after_release2", 64'(header_ready), 64'd1);
        $display("reset-during-learn src=0a0000000099 writes=%0d lc=%0d", n_write - w0, learn_count);
        run_frame(48'h0A0000000099, 48'h020000000101, 4, 1);

        check_eq("one_enable_per_cycle", 64'(multi_en_errs), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1);
    end
endmodule
